jtag_dr_chain: RTL
==================

# jtag_dr_chain

Parametrised JTAG user data-register chain. It shifts command words in from the JTAG TAP and decodes them into DMA setup registers, a data buffer and launch requests, and it shifts status and readback words out. It sits between the ECP5 JTAG primitive (JTCK/JTDI/JSHIFT/JUPDATE/JCE/JRTI) and the DMA controller. It is the successor of the fixed 32+4-bit chain, adding:
- generic data width and buffer depth;
- auto-incrementing buffer pointers;
- a launch queue gated by Run-Test/Idle;
- a sticky status word.

## Interface
Parameters:
- DATA_W, 32, payload width (multiple of 8, ≥16)
- OPC_W, 4, opcode width
- BUF_DEPTH, 16, buffer words (power of 2, ≤256)

Ports:
- JTCK  in  1  clock; all logic on rising edge
- JRST  in  1  reset; synchronous, active-high
- JTDI  in  1  serial data in
- JSHIFT  in  1  shift enable (qualified by JCE)
- JCE  in  1  chain selected
- JUPDATE  in  1  one-cycle update strobe
- JRTI  in  1  TAP in Run-Test/Idle
- JTDO  out  1  serial data out = sr[0]
- dma_busy  in  1  DMA engine busy
- dma_start_wr  out  1  one-cycle pulse, buffer→memory
- dma_start_rd  out  1  one-cycle pulse, memory→buffer
- dma_addr  out  DATA_W  start address
- dma_be  out  DATA_W/8  byte enables
- dma_burst  out  8  burst length minus 1
- buf_addr  in  log2(BUF_DEPTH)  DMA-side buffer index
- buf_rdata  out  DATA_W  buffer[buf_addr], combinational
- buf_we  in  1  DMA-side write
- buf_wdata  in  DATA_W  DMA-side write data

## Operation
- Shift register sr: SR_W = DATA_W+OPC_W bits, plus 1 with the parity option.
- Command layout, LSB-first: sr[OPC_W-1:0] = opcode; sr[OPC_W+DATA_W-1:OPC_W] = payload; parity bit is MSB (when enabled).
- JCE & JSHIFT: sr <= {JTDI, sr[SR_W-1:1]}.
- JCE & !JSHIFT: capture, sr <= {resp, last_opc}; parity bit = even parity of the captured bits.
- JUPDATE: decode the sr contents.
- Opcodes:
  - 0x0 NOP.
  - 0x1 SET_ADDR: dma_addr <= payload; wptr <= rptr <= 0.
  - 0x2 SET_BE: dma_be <= payload[DATA_W/8-1:0].
  - 0x3 SET_BURST: dma_burst <= min(payload[7:0], BUF_DEPTH-1).
  - 0x4 / 0x5 / 0x6: resp <= dma_addr / dma_be / dma_burst (zero-extended).
  - 0x7: resp <= status.
  - 0x8 WR_BUF: buffer[wptr] <= payload; wptr++ (wraps at BUF_DEPTH).
  - 0x9 RD_BUF: resp <= buffer[rptr]; rptr++ (wraps).
  - 0xA LAUNCH_WR, 0xB LAUNCH_RD: if no launch is pending, pending <= 1 and dir <= rd; otherwise set sticky ovr.
  - 0xC CLR: wptr <= rptr <= 0; ovr, err, perr cleared.
  - Others: set sticky err; no other effect.
- Launch release: when pending & JRTI & !dma_busy, assert the dma_start_wr or dma_start_rd pulse for exactly one cycle and clear pending.
- status word, zero-extended: {perr, err, ovr, pending, dma_busy, wptr, rptr}, LSB = rptr.
- DMA-side buffer write (buf_we) takes priority over WR_BUF to the same index in the same cycle; WR_BUF still advances wptr.
- Reset values:
  - sr, resp, dma_addr, dma_burst, pointers, flags, dma_start_*: 0.
  - dma_be: all ones.
  - Buffer contents are not reset.

## Timing
- Capture, shift and update each take effect on the JTCK edge at which they are sampled. JTDO changes one cycle after each shift.
- An RD_* response is visible at the next capture, i.e. one full DR scan later.
- Launch latency: the earliest dma_start pulse comes in the cycle after the update edge, provided JRTI=1 and dma_busy=0. If dma_busy=1, the pulse comes in the first cycle after dma_busy falls while JRTI=1.
- JUPDATE together with JCE is illegal; JUPDATE wins and the shift/capture is ignored.
- JRST asserted mid-scan or with a launch pending: everything returns to reset values next edge; no start pulse is issued.
- Simultaneous release and new launch in one cycle: the release happens, and the new command becomes pending (no ovr).

## Configuration
- JTAG_DR_PARITY_EN defined: SR_W gains an even-parity MSB.
  - On update, if the parity of the whole sr is odd, the command is discarded and sticky perr is set.
  - Captured words carry a valid parity bit.
- Undefined: no parity bit; SR_W = DATA_W+OPC_W; perr reads 0.

## Test plan
- Reset, then capture and shift 36 bits out → JTDO stream all zero. SET_BE readback (0x5) → 0xF.
- Shift 0x555555551, then 0x4, then a capture scan → shifted-out payload 0x55555555, opcode field 0x4.
- WR_BUF payloads 0xABCDEF0, 0xABCDEF1, 0xABCDEF2; DMA side drives buf_addr=2 → buf_rdata=0xABCDEF2; status wptr=3.
- dma_busy=1, LAUNCH_WR → no pulse, status pending=1. Second LAUNCH_RD → ovr=1. Drop dma_busy with JRTI=1 → exactly one dma_start_wr pulse.
- SET_BURST 0xFF with BUF_DEPTH=16 → dma_burst readback 0x0F. Opcode 0xE → err=1. CLR → status 0.
- With JTAG_DR_PARITY_EN: SET_ADDR with a wrong parity bit → dma_addr unchanged, perr=1.

Source files
------------

// File: rtl/jtag_dr_chain.sv
// JTAG user DR chain: shifts command words in, decodes them into DMA setup, buffer and launch requests.
// Optional even-parity MSB on the shift register is enabled by defining JTAG_DR_PARITY_EN.
module jtag_dr_chain #(
  parameter int DATA_W    = 32,
  parameter int OPC_W     = 4,
  parameter int BUF_DEPTH = 16
) (
  input  logic                        JTCK,
  input  logic                        JRST,
  input  logic                        JTDI,
  input  logic                        JSHIFT,
  input  logic                        JCE,
  input  logic                        JUPDATE,
  input  logic                        JRTI,
  output logic                        JTDO,
  input  logic                        dma_busy,
  output logic                        dma_start_wr,
  output logic                        dma_start_rd,
  output logic [DATA_W-1:0]           dma_addr,
  output logic [DATA_W/8-1:0]         dma_be,
  output logic [7:0]                  dma_burst,
  input  logic [$clog2(BUF_DEPTH)-1:0] buf_addr,
  output logic [DATA_W-1:0]           buf_rdata,
  input  logic                        buf_we,
  input  logic [DATA_W-1:0]           buf_wdata
);

  localparam int AW     = $clog2(BUF_DEPTH);
`ifdef JTAG_DR_PARITY_EN
  localparam int PAR_W  = 1;
`else
  localparam int PAR_W  = 0;
`endif
  localparam int CMD_W  = DATA_W + OPC_W;
  localparam int SR_W   = CMD_W + PAR_W;
  localparam int STAT_W = 5 + 2 * AW;

  localparam logic [OPC_W-1:0] OP_NOP       = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_SET_ADDR  = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_SET_BE    = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SET_BURST = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_RD_ADDR   = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_RD_BE     = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_RD_BURST  = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_RD_STAT   = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_WR_BUF    = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_RD_BUF    = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OP_LAUNCH_WR = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OP_LAUNCH_RD = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OP_CLR       = OPC_W'(4'hC);

  logic [SR_W-1:0]     sr_reg, sr_next;
  logic [DATA_W-1:0]   resp_reg, resp_next;
  logic [DATA_W-1:0]   addr_reg, addr_next;
  logic [DATA_W/8-1:0] be_reg, be_next;
  logic [7:0]          burst_reg, burst_next;
  logic [AW-1:0]       wptr_reg, wptr_next;
  logic [AW-1:0]       rptr_reg, rptr_next;
  logic [OPC_W-1:0]    last_opc_reg, last_opc_next;
  logic                ovr_reg, ovr_next;
  logic                err_reg, err_next;
  logic                perr_reg, perr_next;
  logic                pending_reg, pending_next;
  logic                dir_reg, dir_next;

  logic [DATA_W-1:0]   buf_mem [BUF_DEPTH];
  logic                buf_wr_en;

  logic [OPC_W-1:0]    opcode;
  logic [DATA_W-1:0]   payload;
  logic                parity_ok;
  logic                release_now;
  logic [CMD_W-1:0]    cap_word;
  logic [SR_W-1:0]     cap_sr;
  logic [STAT_W-1:0]   status_bits;
  logic [DATA_W-1:0]   status_word;

  assign opcode      = sr_reg[OPC_W-1:0];
  assign payload     = sr_reg[CMD_W-1:OPC_W];
  assign cap_word    = {resp_reg, last_opc_reg};
  assign status_bits = {perr_reg, err_reg, ovr_reg, pending_reg, dma_busy, wptr_reg, rptr_reg};
  assign status_word = DATA_W'(status_bits);

`ifdef JTAG_DR_PARITY_EN
  assign parity_ok = ~^sr_reg;
  assign cap_sr    = {^cap_word, cap_word};
`else
  assign parity_ok = 1'b1;
  assign cap_sr    = cap_word;
`endif

  // Reset gates the release so a launch pending across reset never fires.
  assign release_now  = pending_reg & JRTI & ~dma_busy & ~JRST;
  assign dma_start_wr = release_now & ~dir_reg;
  assign dma_start_rd = release_now & dir_reg;

  assign JTDO      = sr_reg[0];
  assign dma_addr  = addr_reg;
  assign dma_be    = be_reg;
  assign dma_burst = burst_reg;
  assign buf_rdata = buf_mem[buf_addr];

  always_comb begin
    sr_next       = sr_reg;
    resp_next     = resp_reg;
    addr_next     = addr_reg;
    be_next       = be_reg;
    burst_next    = burst_reg;
    wptr_next     = wptr_reg;
    rptr_next     = rptr_reg;
    last_opc_next = last_opc_reg;
    ovr_next      = ovr_reg;
    err_next      = err_reg;
    perr_next     = perr_reg;
    pending_next  = pending_reg;
    dir_next      = dir_reg;
    buf_wr_en     = 1'b0;

    if (release_now) pending_next = 1'b0;

    // Update has priority over a simultaneous shift/capture.
    if (JUPDATE) begin
      if (!parity_ok) begin
        perr_next = 1'b1;
      end else begin
        last_opc_next = opcode;
        case (opcode)
          OP_NOP: ;
          OP_SET_ADDR: begin
            addr_next = payload;
            wptr_next = '0;
            rptr_next = '0;
          end
          OP_SET_BE:    be_next = payload[DATA_W/8-1:0];
          OP_SET_BURST: burst_next = (payload[7:0] > 8'(BUF_DEPTH - 1)) ? 8'(BUF_DEPTH - 1) : payload[7:0];
          OP_RD_ADDR:   resp_next = addr_reg;
          OP_RD_BE:     resp_next = DATA_W'(be_reg);
          OP_RD_BURST:  resp_next = DATA_W'(burst_reg);
          OP_RD_STAT:   resp_next = status_word;
          OP_WR_BUF: begin
            buf_wr_en = 1'b1;
            wptr_next = wptr_reg + 1'b1;
          end
          OP_RD_BUF: begin
            resp_next = buf_mem[rptr_reg];
            rptr_next = rptr_reg + 1'b1;
          end
          OP_LAUNCH_WR, OP_LAUNCH_RD: begin
            if (pending_reg && !release_now) begin
              ovr_next = 1'b1;
            end else begin
              pending_next = 1'b1;
              dir_next     = (opcode == OP_LAUNCH_RD);
            end
          end
          OP_CLR: begin
            wptr_next = '0;
            rptr_next = '0;
            ovr_next  = 1'b0;
            err_next  = 1'b0;
            perr_next = 1'b0;
          end
          default: begin
            err_next      = 1'b1;
            last_opc_next = last_opc_reg;
          end
        endcase
      end
    end else if (JCE) begin
      if (JSHIFT) sr_next = {JTDI, sr_reg[SR_W-1:1]};
      else        sr_next = cap_sr;
    end
  end

  always_ff @(posedge JTCK) begin
    if (JRST) begin
      sr_reg       <= '0;
      resp_reg     <= '0;
      addr_reg     <= '0;
      be_reg       <= '1;
      burst_reg    <= '0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      last_opc_reg <= '0;
      ovr_reg      <= 1'b0;
      err_reg      <= 1'b0;
      perr_reg     <= 1'b0;
      pending_reg  <= 1'b0;
      dir_reg      <= 1'b0;
    end else begin
      sr_reg       <= sr_next;
      resp_reg     <= resp_next;
      addr_reg     <= addr_next;
      be_reg       <= be_next;
      burst_reg    <= burst_next;
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      last_opc_reg <= last_opc_next;
      ovr_reg      <= ovr_next;
      err_reg      <= err_next;
      perr_reg     <= perr_next;
      pending_reg  <= pending_next;
      dir_reg      <= dir_next;
    end
  end

  // Buffer contents survive reset; the DMA-side write wins on an index collision.
  always_ff @(posedge JTCK) begin
    if (!JRST && buf_wr_en && !(buf_we && buf_addr == wptr_reg)) buf_mem[wptr_reg] <= payload;
    if (buf_we) buf_mem[buf_addr] <= buf_wdata;
  end

endmodule
